// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with runtime-loadable pattern and mask, selectable
// overlap, stall enable, registered match pulse and saturating match counter.
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             armed
);

  localparam int VW = $clog2(PAT_W + 1);
  localparam logic [VW-1:0]    V_FULL  = VW'(PAT_W);
  localparam logic [VW-1:0]    V_LAST  = VW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] h_next;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] mask_q;
  logic             ovl_q;
  logic [VW-1:0]    vcnt;
  logic             hit;

  // Compare against the post-shift history so a completing bit matches on the edge that samples it.
  always_comb begin
    h_next = {hist[PAT_W-2:0], din};
    hit    = en && !cfg_load && (vcnt >= V_LAST) &&
             (((h_next ^ pat_q) & mask_q) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= '0;
      mask_q <= '1;
      ovl_q  <= 1'b1;
      hist   <= '0;
      vcnt   <= '0;
    end else if (cfg_load) begin
      pat_q  <= cfg_pattern;
      mask_q <= cfg_mask;
      ovl_q  <= cfg_overlap;
      hist   <= '0;
      vcnt   <= '0;
    end else if (en) begin
      hist <= h_next;
      if (hit && !ovl_q)
        vcnt <= '0;
      else if (vcnt != V_FULL)
        vcnt <= vcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      match <= 1'b0;
    else
      match <= hit;
  end

  // Clear wins over a coincident match; the pulse itself is unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (hit && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
      if (match_cnt == CNT_MAX - 1'b1)
        cnt_sat <= 1'b1;
    end
  end

  assign armed = (vcnt == V_FULL);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed table-driven bench for seq_detect_param: an 8-bit-counter instance and a
// 2-bit-counter instance share stimulus; the narrow one exercises saturation.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       din;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic [3:0] cfg_mask;
  logic       cfg_overlap;
  logic       clr_cnt;
  logic       match, match2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic       cnt_sat, cnt_sat2;
  logic       armed, armed2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt), .match(match), .match_cnt(match_cnt), .cnt_sat(cnt_sat),
    .armed(armed)
  );

  seq_detect_param #(.PAT_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt), .match(match2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2),
    .armed(armed2)
  );

  typedef struct {
    logic       en, din, load;
    logic [3:0] pat, mask;
    logic       ovl, clr;
    logic       m;
    logic [7:0] cnt;
    logic       sat, armed;
    logic       chk2;
    logic [1:0] cnt2;
    logic       sat2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(int e, int d, int ld, int p, int mk, int o, int c,
                             int m, int cn, int s, int a, int k2, int c2, int s2);
    vec_t r;
    r.en = e[0]; r.din = d[0]; r.load = ld[0];
    r.pat = p[3:0]; r.mask = mk[3:0]; r.ovl = o[0]; r.clr = c[0];
    r.m = m[0]; r.cnt = cn[7:0]; r.sat = s[0]; r.armed = a[0];
    r.chk2 = k2[0]; r.cnt2 = c2[1:0]; r.sat2 = s2[0];
    return r;
  endfunction

  // Data bit with en=1; cfg inputs deliberately hold junk that must not be used.
  function automatic vec_t b(int d, int m, int cn, int a);
    return v(1, d, 0, 0, 0, 0, 0, m, cn, 0, a, 0, 0, 0);
  endfunction

  function automatic vec_t st(int d, int cn, int a);
    return v(0, d, 0, 'hF, 0, 1, 0, 0, cn, 0, a, 0, 0, 0);
  endfunction

  function automatic vec_t ld(int p, int mk, int o, int c, int cn);
    return v(0, 0, 1, p, mk, o, c, 0, cn, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t sb(int m, int cn, int a, int c2, int s2);
    return v(1, 1, 0, 0, 0, 0, 0, m, cn, 0, a, 1, c2, s2);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
    if (got !== want) begin
      nerr++;
      $display("FAIL vec%0d %s: got %0h want %0h", idx, name, got, want);
    end
  endtask

  task automatic check(input int idx, input vec_t e);
    nvec++;
    chk("match", idx, {7'b0, match}, {7'b0, e.m});
    chk("match_cnt", idx, match_cnt, e.cnt);
    chk("cnt_sat", idx, {7'b0, cnt_sat}, {7'b0, e.sat});
    chk("armed", idx, {7'b0, armed}, {7'b0, e.armed});
    chk("match2", idx, {7'b0, match2}, {7'b0, e.m});
    chk("armed2", idx, {7'b0, armed2}, {7'b0, e.armed});
    if (e.chk2) begin
      chk("match_cnt2", idx, {6'b0, match_cnt2}, {6'b0, e.cnt2});
      chk("cnt_sat2", idx, {7'b0, cnt_sat2}, {7'b0, e.sat2});
    end
  endtask

  task automatic apply(input int idx, input vec_t e);
    en = e.en; din = e.din; cfg_load = e.load;
    cfg_pattern = e.pat; cfg_mask = e.mask; cfg_overlap = e.ovl; clr_cnt = e.clr;
    @(posedge clk);
    #1;
    check(idx, e);
  endtask

  initial begin
    // overlapping 1101 on 1,1,0,1,1,0,1
    tbl.push_back(ld('b1101, 'b1111, 1, 1, 0));
    tbl.push_back(b(1,0,0,0)); tbl.push_back(b(1,0,0,0)); tbl.push_back(b(0,0,0,0));
    tbl.push_back(b(1,1,1,1)); tbl.push_back(b(1,0,1,1)); tbl.push_back(b(0,0,1,1));
    tbl.push_back(b(1,1,2,1)); tbl.push_back(st(1,2,1));
    // non-overlapping, same stream
    tbl.push_back(ld('b1101, 'b1111, 0, 1, 0));
    tbl.push_back(b(1,0,0,0)); tbl.push_back(b(1,0,0,0)); tbl.push_back(b(0,0,0,0));
    tbl.push_back(b(1,1,1,0)); tbl.push_back(b(1,0,1,0)); tbl.push_back(b(0,0,1,0));
    tbl.push_back(b(1,0,1,0));
    // non-overlapping 1101_1101
    tbl.push_back(ld('b1101, 'b1111, 0, 1, 0));
    tbl.push_back(b(1,0,0,0)); tbl.push_back(b(1,0,0,0)); tbl.push_back(b(0,0,0,0));
    tbl.push_back(b(1,1,1,0)); tbl.push_back(b(1,0,1,0)); tbl.push_back(b(1,0,1,0));
    tbl.push_back(b(0,0,1,0)); tbl.push_back(b(1,1,2,0));
    // masked compare: 1001 matches 1x01, 1011 does not
    tbl.push_back(ld('b1101, 'b1011, 1, 1, 0));
    tbl.push_back(b(1,0,0,0)); tbl.push_back(b(0,0,0,0)); tbl.push_back(b(0,0,0,0));
    tbl.push_back(b(1,1,1,1));
    tbl.push_back(ld('b1101, 'b1011, 1, 0, 1));
    tbl.push_back(b(1,0,1,0)); tbl.push_back(b(0,0,1,0)); tbl.push_back(b(1,0,1,0));
    tbl.push_back(b(1,0,1,1));
    // stall with din toggling
    tbl.push_back(ld('b1101, 'b1111, 1, 1, 0));
    tbl.push_back(b(1,0,0,0)); tbl.push_back(b(1,0,0,0));
    tbl.push_back(st(1,0,0)); tbl.push_back(st(0,0,0)); tbl.push_back(st(1,0,0));
    tbl.push_back(b(0,0,0,0)); tbl.push_back(b(1,1,1,1)); tbl.push_back(st(0,1,1));
    // cfg_load with en=1 discards the sampled bit
    tbl.push_back(ld('b1101, 'b1111, 1, 1, 0));
    tbl.push_back(b(1,0,0,0)); tbl.push_back(b(1,0,0,0)); tbl.push_back(b(0,0,0,0));
    tbl.push_back(v(1, 1, 1, 'b1101, 'b1111, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(b(1,0,0,0)); tbl.push_back(b(1,0,0,0)); tbl.push_back(b(0,0,0,0));
    tbl.push_back(b(1,1,1,1));
    // all-zero mask matches once enough bits are present
    tbl.push_back(ld('b1101, 'b0000, 1, 1, 0));
    tbl.push_back(b(0,0,0,0)); tbl.push_back(b(1,0,0,0)); tbl.push_back(b(0,0,0,0));
    tbl.push_back(b(1,1,1,1)); tbl.push_back(b(0,1,2,1));
    // saturation on the 2-bit counter, then clr_cnt on a match edge
    tbl.push_back(v(0, 0, 1, 'b1111, 'b1111, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(sb(0,0,0,0,0)); tbl.push_back(sb(0,0,0,0,0)); tbl.push_back(sb(0,0,0,0,0));
    tbl.push_back(sb(1,1,1,1,0)); tbl.push_back(sb(1,2,1,2,0)); tbl.push_back(sb(1,3,1,3,1));
    tbl.push_back(sb(1,4,1,3,1)); tbl.push_back(sb(1,5,1,3,1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(sb(1,1,1,1,0));

    rst = 1'b1; en = 1'b0; din = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_mask = '0; cfg_overlap = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    check(-1, v(0,0,0,0,0,0,0, 0,0,0,0, 1,0,0));
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) apply(i, tbl[i]);

    // asynchronous reset while a match pulse and nonzero count are showing
    apply(1000, ld('b1101, 'b1011, 0, 1, 0));
    apply(1001, b(1,0,0,0)); apply(1002, b(1,0,0,0)); apply(1003, b(0,0,0,0));
    apply(1004, b(1,1,1,0));
    #2;
    rst = 1'b1;
    #1;
    check(1005, v(0,0,0,0,0,0,0, 0,0,0,0, 1,0,0));
    @(negedge clk);
    rst = 1'b0;
    // reset config is pattern 0000, full mask, overlap on
    apply(1006, b(1,0,0,0)); apply(1007, b(0,0,0,0)); apply(1008, b(0,0,0,0));
    apply(1009, b(0,0,0,1)); apply(1010, b(0,1,1,1)); apply(1011, b(0,1,2,1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
